// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of a single-port RAM.
// Port 0 (cpu) and port 1 (loader/IO) compete for one RAM command slot per
// cycle. The current owner may keep the bus for up to MAX_HOLD consecutive
// grants while the other port waits; a lone requester is never throttled.
// Read data comes back READ_LAT cycles after the grant and is steered to the
// port that issued the read using a tag carried down a small return pipeline.
module mem_arbiter #(
  parameter int ADDR_W   = 9,
  parameter int DATA_W   = 16,
  parameter int READ_LAT = 1,
  parameter int MAX_HOLD = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        r0_cmd,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  output logic              r0_gnt,
  output logic              r0_rvalid,
  output logic [DATA_W-1:0] r0_rdata,
  input  logic [1:0]        r1_cmd,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r1_gnt,
  output logic              r1_rvalid,
  output logic [DATA_W-1:0] r1_rdata,
  output logic [1:0]        ram_cmd,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              busy
);

  localparam logic [1:0] MNONE  = 2'b00;
  localparam logic [1:0] MREAD  = 2'b01;
  localparam logic [1:0] MWRITE = 2'b10;
  localparam logic [3:0] MAX_HOLD_C = 4'(MAX_HOLD);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_P0   = 2'd1,
    OWN_P1   = 2'd2
  } owner_t;

  owner_t     owner;
  logic       last_p1;   // 1 when port 1 was the most recent new owner
  logic [3:0] hold_cnt;

  logic req0, req1;
  logic own_req, oth_req;
  logic gnt0, gnt1;
  logic push_rd;

  logic [READ_LAT-1:0] vld_p;
  logic [READ_LAT-1:0] tag_p;
  logic                vld_tail, tag_tail;

  // Saturating increment for the consecutive-grant counter.
  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  assign req0 = (r0_cmd == MREAD) || (r0_cmd == MWRITE);
  assign req1 = (r1_cmd == MREAD) || (r1_cmd == MWRITE);

  // Grant decision: owner keeps the bus until its hold budget runs out while
  // the other port waits; ties with no owner go to the port not granted last.
  // Grants are forced off while reset is asserted so the RAM sees MNONE.
  always_comb begin
    gnt0    = 1'b0;
    gnt1    = 1'b0;
    own_req = ((owner == OWN_P0) && req0) || ((owner == OWN_P1) && req1);
    oth_req = ((owner == OWN_P0) && req1) || ((owner == OWN_P1) && req0);
    if (own_req && (!oth_req || (hold_cnt < MAX_HOLD_C))) begin
      gnt0 = (owner == OWN_P0);
      gnt1 = (owner == OWN_P1);
    end else if (req0 && !req1) begin
      gnt0 = 1'b1;
    end else if (req1 && !req0) begin
      gnt1 = 1'b1;
    end else if (req0 && req1) begin
      if (owner == OWN_NONE) begin
        gnt0 = last_p1;
        gnt1 = !last_p1;
      end else begin
        gnt0 = (owner == OWN_P1);
        gnt1 = (owner == OWN_P0);
      end
    end
    if (!reset) begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
    end
  end

  assign r0_gnt = gnt0;
  assign r1_gnt = gnt1;

  // Route the winning port's command to the RAM; idle bus is all zeros.
  always_comb begin
    ram_cmd   = MNONE;
    ram_addr  = '0;
    ram_wdata = '0;
    if (gnt0) begin
      ram_cmd   = r0_cmd;
      ram_addr  = r0_addr;
      ram_wdata = r0_wdata;
    end else if (gnt1) begin
      ram_cmd   = r1_cmd;
      ram_addr  = r1_addr;
      ram_wdata = r1_wdata;
    end
  end

  // Ownership and hold counter; any idle cycle releases ownership.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner    <= OWN_NONE;
      last_p1  <= 1'b1;
      hold_cnt <= 4'd0;
    end else if (gnt0 || gnt1) begin
      if ((gnt0 && (owner == OWN_P0)) || (gnt1 && (owner == OWN_P1))) begin
        hold_cnt <= sat_inc(hold_cnt);
      end else begin
        owner    <= gnt0 ? OWN_P0 : OWN_P1;
        last_p1  <= gnt1;
        hold_cnt <= 4'd1;
      end
    end else begin
      owner    <= OWN_NONE;
      hold_cnt <= 4'd0;
    end
  end

  assign push_rd = (gnt0 && (r0_cmd == MREAD)) || (gnt1 && (r1_cmd == MREAD));

  // Return pipeline: stage 0 captures the read grant, the tail lines up with
  // the RAM output. Reset empties it so in-flight reads are dropped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_p <= '0;
      tag_p <= '0;
    end else begin
      vld_p[0] <= push_rd;
      tag_p[0] <= gnt1;
      for (int i = 1; i < READ_LAT; i++) begin
        vld_p[i] <= vld_p[i-1];
        tag_p[i] <= tag_p[i-1];
      end
    end
  end

  assign vld_tail  = vld_p[READ_LAT-1];
  assign tag_tail  = tag_p[READ_LAT-1];
  assign r0_rvalid = vld_tail && !tag_tail;
  assign r1_rvalid = vld_tail && tag_tail;
  assign r0_rdata  = r0_rvalid ? ram_rdata : '0;
  assign r1_rdata  = r1_rvalid ? ram_rdata : '0;
  assign busy      = |vld_p;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus randomized traffic checked
// against a queue-based reference model of the arbitration rules.
module tb_mem_arbiter;

  localparam int AW   = 9;
  localparam int DW   = 16;
  localparam int MAXH = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance, READ_LAT = 1
  logic          reset;
  logic [1:0]    r0_cmd, r1_cmd;
  logic [AW-1:0] r0_addr, r1_addr;
  logic [DW-1:0] r0_wdata, r1_wdata;
  logic          r0_gnt, r1_gnt, r0_rvalid, r1_rvalid, busy;
  logic [DW-1:0] r0_rdata, r1_rdata;
  logic [1:0]    ram_cmd;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;

  // Second instance, READ_LAT = 2, for the mid-flight reset scenario
  logic          reset2;
  logic [1:0]    s0_cmd, s1_cmd;
  logic [AW-1:0] s0_addr, s1_addr;
  logic [DW-1:0] s0_wdata, s1_wdata;
  logic          s0_gnt, s1_gnt, s0_rvalid, s1_rvalid, busy2;
  logic [DW-1:0] s0_rdata, s1_rdata;
  logic [1:0]    ram_cmd2;
  logic [AW-1:0] ram_addr2;
  logic [DW-1:0] ram_wdata2;
  logic [DW-1:0] ram_rdata2;
  assign ram_rdata2 = 16'hA5A5;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .READ_LAT(1), .MAX_HOLD(MAXH)) u_dut (
    .clk(clk), .reset(reset),
    .r0_cmd(r0_cmd), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
    .r1_cmd(r1_cmd), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
    .ram_cmd(ram_cmd), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .busy(busy)
  );

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .READ_LAT(2), .MAX_HOLD(MAXH)) u_dut2 (
    .clk(clk), .reset(reset2),
    .r0_cmd(s0_cmd), .r0_addr(s0_addr), .r0_wdata(s0_wdata),
    .r0_gnt(s0_gnt), .r0_rvalid(s0_rvalid), .r0_rdata(s0_rdata),
    .r1_cmd(s1_cmd), .r1_addr(s1_addr), .r1_wdata(s1_wdata),
    .r1_gnt(s1_gnt), .r1_rvalid(s1_rvalid), .r1_rdata(s1_rdata),
    .ram_cmd(ram_cmd2), .ram_addr(ram_addr2), .ram_wdata(ram_wdata2),
    .ram_rdata(ram_rdata2), .busy(busy2)
  );

  function automatic logic [DW-1:0] init_val(input int a);
    return (a == 5) ? 16'h1234 : 16'((a * 37) + 256);
  endfunction

  // RAM with one cycle read latency, preloaded on the first clock
  logic [DW-1:0] ram_mem [512];
  logic          ram_init_done = 1'b0;
  always @(posedge clk) begin
    if (!ram_init_done) begin
      for (int i = 0; i < 512; i++) ram_mem[i] <= init_val(i);
      ram_init_done <= 1'b1;
    end else begin
      if (ram_cmd == 2'b10) ram_mem[ram_addr] <= ram_wdata;
      if (ram_cmd == 2'b01) ram_rdata <= ram_mem[ram_addr];
    end
  end

  int errors = 0;
  int checks = 0;

  // Reference model state
  typedef struct {
    int            port;
    logic [DW-1:0] data;
    int            due;
  } ret_t;
  ret_t          retq[$];
  logic [DW-1:0] shadow [512];
  int            m_owner;  // -1 none, 0, 1
  int            m_last;
  int            m_hold;
  int            cyc;
  int            last_g;
  int            dut_hist[$];
  logic [DW-1:0] cap_r1_rdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_last  = 1;
    m_hold  = 0;
    retq.delete();
  endtask

  function automatic bit is_req(input logic [1:0] c);
    return (c == 2'b01) || (c == 2'b10);
  endfunction

  // One bus cycle: predict, compare at negedge, update model, advance.
  task automatic step();
    int g;
    bit q0, q1, own_q, oth_q, rv0, rv1;
    logic [1:0] ec;
    logic [AW-1:0] ea;
    logic [DW-1:0] ew, rd;
    @(negedge clk);
    q0 = is_req(r0_cmd);
    q1 = is_req(r1_cmd);
    own_q = (m_owner == 0) ? q0 : (m_owner == 1) ? q1 : 1'b0;
    oth_q = (m_owner == 0) ? q1 : (m_owner == 1) ? q0 : 1'b0;
    g = -1;
    if (own_q && (!oth_q || m_hold < MAXH)) g = m_owner;
    else if (q0 && !q1) g = 0;
    else if (q1 && !q0) g = 1;
    else if (q0 && q1) g = (m_owner < 0) ? 1 - m_last : 1 - m_owner;
    ec = 2'b00; ea = '0; ew = '0;
    if (g == 0) begin ec = r0_cmd; ea = r0_addr; ew = r0_wdata; end
    if (g == 1) begin ec = r1_cmd; ea = r1_addr; ew = r1_wdata; end
    chk("r0_gnt", r0_gnt, g == 0);
    chk("r1_gnt", r1_gnt, g == 1);
    chk("ram_cmd", ram_cmd, ec);
    chk("ram_addr", ram_addr, ea);
    chk("ram_wdata", ram_wdata, ew);
    chk("busy", busy, retq.size() > 0);
    rv0 = 0; rv1 = 0; rd = '0;
    if (retq.size() > 0 && retq[0].due == cyc) begin
      if (retq[0].port == 0) rv0 = 1; else rv1 = 1;
      rd = retq[0].data;
      void'(retq.pop_front());
    end
    chk("r0_rvalid", r0_rvalid, rv0);
    chk("r1_rvalid", r1_rvalid, rv1);
    chk("r0_rdata", r0_rdata, rv0 ? rd : 16'h0);
    chk("r1_rdata", r1_rdata, rv1 ? rd : 16'h0);
    dut_hist.push_back(r1_gnt ? 1 : (r0_gnt ? 0 : -1));
    cap_r1_rdata = r1_rdata;
    if (g >= 0) begin
      if (ec == 2'b10) shadow[ea] = ew;
      if (ec == 2'b01) retq.push_back('{g, shadow[ea], cyc + 1});
      if (g == m_owner) begin
        m_hold = (m_hold < 15) ? m_hold + 1 : 15;
      end else begin
        m_owner = g;
        m_last  = g;
        m_hold  = 1;
      end
    end else begin
      m_owner = -1;
      m_hold  = 0;
    end
    last_g = g;
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    r0_cmd = 2'b00; r1_cmd = 2'b00;
    @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ram_cmd", ram_cmd, 2'b00);
    @(posedge clk);
    #1;
    reset = 1'b1;
    model_reset();
  endtask

  initial begin
    int base;
    int n0;
    int k;
    int exp_seq[12] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0};
    for (int i = 0; i < 512; i++) shadow[i] = init_val(i);
    model_reset();
    cyc = 0;
    last_g = -1;
    reset = 1'b0; reset2 = 1'b0;
    r0_cmd = 2'b01; r0_addr = 9'h005; r0_wdata = '0;
    r1_cmd = 2'b10; r1_addr = 9'h006; r1_wdata = 16'h7777;
    s0_cmd = 2'b00; s0_addr = '0; s0_wdata = '0;
    s1_cmd = 2'b00; s1_addr = '0; s1_wdata = '0;

    // Reset state with requests present
    repeat (2) @(negedge clk);
    chk("rst_r0_gnt", r0_gnt, 1'b0);
    chk("rst_r1_gnt", r1_gnt, 1'b0);
    chk("rst_ram_cmd", ram_cmd, 2'b00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_r0_rvalid", r0_rvalid, 1'b0);
    chk("rst_r0_rdata", r0_rdata, 16'h0);
    @(posedge clk);
    #1;
    reset = 1'b1; reset2 = 1'b1;
    r0_cmd = 2'b00; r1_cmd = 2'b00;

    // Single read from port 0
    r0_cmd = 2'b01; r0_addr = 9'h005;
    step();
    r0_cmd = 2'b00;
    step();

    // Both ports reading continuously: burst-hold rotation
    pulse_reset();
    r0_cmd = 2'b01; r0_addr = 9'h010;
    r1_cmd = 2'b01; r1_addr = 9'h020;
    base = dut_hist.size();
    for (int i = 0; i < 12; i++) step();
    for (int i = 0; i < 12; i++) chk("t2_grant_seq", dut_hist[base + i], exp_seq[i]);
    r0_cmd = 2'b00; r1_cmd = 2'b00;
    step();

    // Port 1 write then read of the same address
    r1_cmd = 2'b10; r1_addr = 9'h1FF; r1_wdata = 16'hBEEF;
    step();
    r1_cmd = 2'b01;
    step();
    r1_cmd = 2'b00;
    step();
    chk("t3_rdata", cap_r1_rdata, 16'hBEEF);

    // Lone requester for 20 cycles, then port 1 joins
    base = dut_hist.size();
    for (int i = 0; i < 20; i++) begin
      r0_cmd = 2'b01; r0_addr = 9'(i);
      step();
    end
    n0 = 0;
    for (int i = 0; i < 20; i++) if (dut_hist[base + i] == 0) n0++;
    chk("t4_lone_grants", n0, 20);
    r1_cmd = 2'b01; r1_addr = 9'h030;
    step();
    chk("t4_switch", dut_hist[dut_hist.size() - 1], 1);

    // Reserved command 11 counts as idle and releases ownership
    r0_cmd = 2'b11;
    r1_cmd = 2'b00;
    step();
    chk("t6_no_grant", dut_hist[dut_hist.size() - 1], -1);
    r0_cmd = 2'b01; r0_addr = 9'h040;
    r1_cmd = 2'b01;
    step();
    chk("t6_tie_p0", dut_hist[dut_hist.size() - 1], 0);
    r0_cmd = 2'b00; r1_cmd = 2'b00;
    step();

    // Randomized traffic, each port holding its command until granted
    for (int n = 0; n < 400; n++) begin
      if (!is_req(r0_cmd) || last_g == 0) begin
        k = $urandom_range(0, 9);
        r0_cmd   = (k < 3) ? 2'b00 : (k == 3) ? 2'b11 : (k < 7) ? 2'b01 : 2'b10;
        r0_addr  = ($urandom_range(0, 7) == 0) ? 9'h1FF : 9'($urandom_range(0, 15));
        r0_wdata = 16'($urandom);
      end
      if (!is_req(r1_cmd) || last_g == 1) begin
        k = $urandom_range(0, 9);
        r1_cmd   = (k < 3) ? 2'b00 : (k == 3) ? 2'b11 : (k < 7) ? 2'b01 : 2'b10;
        r1_addr  = ($urandom_range(0, 7) == 0) ? 9'h1FF : 9'($urandom_range(0, 15));
        r1_wdata = 16'($urandom);
      end
      step();
    end
    r0_cmd = 2'b00; r1_cmd = 2'b00;
    repeat (3) step();

    // READ_LAT=2 instance: reset while a read is in flight
    s0_cmd = 2'b01; s0_addr = 9'h003;
    @(negedge clk);
    chk("t5_gnt", s0_gnt, 1'b1);
    chk("t5_ram_cmd", ram_cmd2, 2'b01);
    chk("t5_ram_addr", ram_addr2, 9'h003);
    chk("t5_ram_wdata", ram_wdata2, 16'h0);
    @(posedge clk);
    #1;
    reset2 = 1'b0;
    s1_cmd = 2'b01; s1_addr = 9'h004;
    @(negedge clk);
    chk("t5_rst_gnt0", s0_gnt, 1'b0);
    chk("t5_rst_gnt1", s1_gnt, 1'b0);
    chk("t5_rst_ram_cmd", ram_cmd2, 2'b00);
    chk("t5_rst_busy", busy2, 1'b0);
    chk("t5_rst_rvalid", s0_rvalid, 1'b0);
    @(posedge clk);
    #1;
    reset2 = 1'b1;
    @(negedge clk);
    chk("t5_dropped_rvalid", s0_rvalid, 1'b0);
    chk("t5_post_busy", busy2, 1'b0);
    chk("t5_tie_gnt0", s0_gnt, 1'b1);
    chk("t5_tie_gnt1", s1_gnt, 1'b0);
    @(posedge clk);
    #1;
    s0_cmd = 2'b00; s1_cmd = 2'b00;
    @(negedge clk);
    chk("t5_busy_inflight", busy2, 1'b1);
    chk("t5_early_rvalid", s0_rvalid, 1'b0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("t5_rvalid", s0_rvalid, 1'b1);
    chk("t5_rdata", s0_rdata, 16'hA5A5);
    chk("t5_r1_rvalid", s1_rvalid, 1'b0);
    chk("t5_r1_rdata", s1_rdata, 16'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
